// File: rtl/prefetch_buffer.sv
// prefetch_buffer: issues word-addressed instruction reads, queues the
// returned words with their PC and hands them to decode over valid/ready.
// Ports: clk, n_reset (async, active low)
//   memory side : addr, trans, write, rdata, abort
//   redirect    : flush_i, flush_pc_i
//   decode side : valid_o, ready_i, instr_o, pc_o, abort_o
`timescale 1ns/1ps

module prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        n_reset,
  output logic [31:0] addr,
  output logic [1:0]  trans,
  output logic        write,
  input  logic [31:0] rdata,
  input  logic        abort,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        abort_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    START,
    SEQ,
    HALT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    trans_q, trans_d;
  logic          rsp_pend_q, rsp_pend_d;
  logic [31:0]   rsp_addr_q, rsp_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [31:0]   head_instr_q, head_instr_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic          head_abt_q, head_abt_d;

  logic [31:0]   mem_instr_q [DEPTH];
  logic [31:0]   mem_pc_q    [DEPTH];
  logic          mem_abt_q   [DEPTH];

  logic          push;
  logic          pop;
  logic          hit_abort;
  logic          issue;
  logic [31:0]   wdata;

  // push: a response that is still wanted lands this cycle
  always_comb begin
    push      = rsp_pend_q & ~flush_i;
    pop       = valid_q & ready_i & ~flush_i;
    hit_abort = push & abort;
    wdata     = abort ? 32'h0 : rdata;
  end

  // FIFO pointers, count and the registered head view
  always_comb begin
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    head_abt_d   = head_abt_q;
    if (flush_i) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
    end
    valid_d = (cnt_d != '0);
    if (cnt_d == '0) begin
      head_instr_d = 32'h0;
      head_pc_d    = 32'h0;
      head_abt_d   = 1'b0;
    end else if (push && (cnt_q == CW'(pop))) begin
      // the entry written this edge becomes the head directly
      head_instr_d = wdata;
      head_pc_d    = rsp_addr_q;
      head_abt_d   = abort;
    end else if (pop) begin
      head_instr_d = mem_instr_q[rd_ptr_d];
      head_pc_d    = mem_pc_q[rd_ptr_d];
      head_abt_d   = mem_abt_q[rd_ptr_d];
    end
  end

  // fetch control: the next request is decided one cycle ahead
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    trans_d    = 2'b00;
    addr_d     = addr_q;
    rsp_addr_d = addr_q;
    issue      = 1'b0;
    // a request on the bus now becomes the pending response,
    // unless a flush or an abort makes it stale
    rsp_pend_d = (trans_q != 2'b00) & ~flush_i & ~hit_abort;
    if (flush_i) begin
      state_d    = START;
      fetch_pc_d = flush_pc_i;
    end else begin
      if (hit_abort) begin
        state_d = HALT;
      end
      // queued plus in-flight must stay within DEPTH
      issue = (state_d != HALT) &&
              ((cnt_d + CW'(rsp_pend_d)) < CW'(DEPTH));
    end
    if (issue) begin
      unique case (state_d)
        START:   trans_d = 2'b10;
        SEQ:     trans_d = 2'b11;
        default: trans_d = 2'b00;
      endcase
      addr_d     = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd1;
      state_d    = SEQ;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= START;
      fetch_pc_q   <= RESET_PC;
      addr_q       <= 32'h0;
      trans_q      <= 2'b00;
      rsp_pend_q   <= 1'b0;
      rsp_addr_q   <= 32'h0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      head_instr_q <= 32'h0;
      head_pc_q    <= 32'h0;
      head_abt_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      addr_q       <= addr_d;
      trans_q      <= trans_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_addr_q   <= rsp_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      head_abt_q   <= head_abt_d;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_instr_q[i] <= 32'h0;
        mem_pc_q[i]    <= 32'h0;
        mem_abt_q[i]   <= 1'b0;
      end
    end else if (push) begin
      mem_instr_q[wr_ptr_q] <= wdata;
      mem_pc_q[wr_ptr_q]    <= rsp_addr_q;
      mem_abt_q[wr_ptr_q]   <= abort;
    end
  end

  assign addr    = addr_q;
  assign trans   = trans_q;
  assign write   = 1'b0;
  assign valid_o = valid_q;
  assign instr_o = head_instr_q;
  assign pc_o    = head_pc_q;
  assign abort_o = head_abt_q;

endmodule
